// File: rtl/pipe_comparator_pkg.sv
// ============================================================================
// Module  : pipe_comparator_pkg
// Brief   : Shared types and elaboration helpers for the pipelined comparator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_comparator_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_LT = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  localparam int DEF_N     = 8;
  localparam int DEF_CHUNK = 3;
  localparam int DEF_CNT_W = 8;

  function automatic int calc_stages(input int n, input int chunk);
    return (n + 1) / chunk;
  endfunction

  function automatic bit width_ok(input int n, input int chunk);
    return (chunk > 0) && (((n + 1) % chunk) == 0);
  endfunction

  // An undecided walk means every slice matched.
  function automatic cmp_res_t encode_res(input logic decided, input logic res_lt);
    cmp_res_t res;
    res = CMP_EQ;
    if (decided) begin
      res = res_lt ? CMP_LT : CMP_GT;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_cmp_stage.sv
// ============================================================================
// Module  : pipe_cmp_stage
// Brief   : One MSB-first slice compare with optional pipeline register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_cmp_stage #(
  parameter int N       = 8,
  parameter int CHUNK   = 3,
  parameter int K       = 0,
  parameter bit REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic         decided_i,
  input  logic         res_lt_i,
  input  logic [N:0]   x_i,
  input  logic [N:0]   y_i,
  output logic         valid_o,
  output logic         decided_o,
  output logic         res_lt_o,
  output logic [N:0]   x_o,
  output logic [N:0]   y_o
);

  localparam int SLICE_MSB = N - K * CHUNK;

  logic [CHUNK-1:0] w_xs;
  logic [CHUNK-1:0] w_ys;
  logic             decided_d;
  logic             res_lt_d;

  assign w_xs = x_i[SLICE_MSB -: CHUNK];
  assign w_ys = y_i[SLICE_MSB -: CHUNK];

  // Once an earlier slice has decided, later slices must not override it.
  always_comb begin
    decided_d = decided_i;
    res_lt_d  = res_lt_i;
    if (!decided_i && (w_xs != w_ys)) begin
      decided_d = 1'b1;
      res_lt_d  = (w_xs < w_ys);
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic       valid_q;
      logic       decided_q;
      logic       res_lt_q;
      logic [N:0] x_q;
      logic [N:0] y_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q   <= 1'b0;
          decided_q <= 1'b0;
          res_lt_q  <= 1'b0;
          x_q       <= '0;
          y_q       <= '0;
        end else if (adv_i) begin
          valid_q   <= valid_i;
          decided_q <= decided_d;
          res_lt_q  <= res_lt_d;
          x_q       <= x_i;
          y_q       <= y_i;
        end
      end

      assign valid_o   = valid_q;
      assign decided_o = decided_q;
      assign res_lt_o  = res_lt_q;
      assign x_o       = x_q;
      assign y_o       = y_q;
    end else begin : g_comb
      // The top-level output register acts as this stage's register.
      logic w_unused_ctl;
      assign w_unused_ctl = ^{clk, reset, adv_i};

      assign valid_o   = valid_i;
      assign decided_o = decided_d;
      assign res_lt_o  = res_lt_d;
      assign x_o       = x_i;
      assign y_o       = y_i;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pipe_comparator.sv
// ============================================================================
// Module  : pipe_comparator
// Brief   : Pipelined signed/unsigned magnitude comparator with lt statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_comparator
  import pipe_comparator_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CHUNK = DEF_CHUNK,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       x,
  input  logic [N:0]       y,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] lt_count
);

  localparam int STAGES = calc_stages(N, CHUNK);

  generate
    if (!width_ok(N, CHUNK)) begin : g_width_check
      $error("pipe_comparator: operand width N+1 must be a multiple of CHUNK");
    end
  endgenerate

  logic              w_adv;
  logic [N:0]        w_x_cap;
  logic [N:0]        w_y_cap;
  logic [STAGES:0]   w_valid;
  logic [STAGES:0]   w_decided;
  logic [STAGES:0]   w_res_lt;
  logic [N:0]        w_x [STAGES+1];
  logic [N:0]        w_y [STAGES+1];
  cmp_res_t          w_res;
  logic              w_unused_ops;

  logic              out_valid_q;
  logic              lt_q;
  logic              eq_q;
  logic              gt_q;
  logic [CNT_W-1:0]  lt_count_q;
  logic [CNT_W-1:0]  lt_count_d;

  assign w_adv    = !out_valid_q || out_ready;
  assign in_ready = w_adv;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_x_cap = signed_mode ? {~x[N], x[N-1:0]} : x;
  assign w_y_cap = signed_mode ? {~y[N], y[N-1:0]} : y;

  assign w_valid[0]   = in_valid;
  assign w_decided[0] = 1'b0;
  assign w_res_lt[0]  = 1'b0;
  assign w_x[0]       = w_x_cap;
  assign w_y[0]       = w_y_cap;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_cmp_stage #(
        .N       (N),
        .CHUNK   (CHUNK),
        .K       (k),
        .REG_OUT (k < STAGES - 1)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .adv_i     (w_adv),
        .valid_i   (w_valid[k]),
        .decided_i (w_decided[k]),
        .res_lt_i  (w_res_lt[k]),
        .x_i       (w_x[k]),
        .y_i       (w_y[k]),
        .valid_o   (w_valid[k+1]),
        .decided_o (w_decided[k+1]),
        .res_lt_o  (w_res_lt[k+1]),
        .x_o       (w_x[k+1]),
        .y_o       (w_y[k+1])
      );
    end
  endgenerate

  assign w_unused_ops = ^{w_x[STAGES], w_y[STAGES]};
  assign w_res        = encode_res(w_decided[STAGES], w_res_lt[STAGES]);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else if (w_adv) begin
      out_valid_q <= w_valid[STAGES];
      lt_q        <= w_valid[STAGES] && (w_res == CMP_LT);
      eq_q        <= w_valid[STAGES] && (w_res == CMP_EQ);
      gt_q        <= w_valid[STAGES] && (w_res == CMP_GT);
    end
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    lt_count_d = lt_count_q;
    if (cnt_clear) begin
      lt_count_d = '0;
    end else if (out_valid_q && out_ready && lt_q && (lt_count_q != {CNT_W{1'b1}})) begin
      lt_count_d = lt_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lt_count_q <= '0;
    end else begin
      lt_count_q <= lt_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt_count  = lt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_comparator.sv
// ============================================================================
// Module  : tb_pipe_comparator
// Brief   : Self-checking bench for pipe_comparator (N=8, CHUNK=3, CNT_W=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_comparator;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] x;
  logic [8:0] y;
  logic       signed_mode;
  logic       out_valid;
  logic       out_ready;
  logic       lt, eq, gt;
  logic       cnt_clear;
  logic [7:0] lt_count;

  pipe_comparator #(.N(8), .CHUNK(3), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt),
    .cnt_clear   (cnt_clear),
    .lt_count    (lt_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [2:0] q[$];
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] cnt_now;
  logic [2:0] exp_res = 3'b000;
  logic [2:0] head_exp;
  bit         has_head;
  bit         underflow = 0;
  logic       obs_ir, obs_ov, obs_acc, obs_del;
  logic [2:0] obs_res;
  logic [7:0] obs_cnt;

  // Reference: plain integer comparison in the selected number system.
  function automatic logic [2:0] ref_cmp(input logic [8:0] a, input logic [8:0] b, input logic s);
    int av, bv;
    if (s) begin
      av = $signed(a);
      bv = $signed(b);
    end else begin
      av = int'(a);
      bv = int'(b);
    end
    if (av < bv) return R_LT;
    if (av > bv) return R_GT;
    return R_EQ;
  endfunction

  function automatic logic [8:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 9'h000;
      1:       return 9'h1FF;
      2:       return 9'h100;
      3:       return 9'h0FF;
      default: return 9'($urandom);
    endcase
  endfunction

  // Drives one cycle, samples at the falling edge and updates the model.
  task automatic run_cycle(input logic v, input logic [8:0] xv, input logic [8:0] yv,
                           input logic s, input logic ordy);
    in_valid = v; x = xv; y = yv; signed_mode = s; out_ready = ordy;
    @(negedge clk);
    obs_ir  = in_ready;
    obs_ov  = out_valid;
    obs_res = {lt, eq, gt};
    obs_cnt = lt_count;
    obs_acc = v && in_ready;
    obs_del = out_valid && ordy;
    cnt_now = exp_cnt;
    has_head = (q.size() > 0);
    head_exp = has_head ? q[0] : 3'bxxx;
    if (reset) begin
      q.delete();
      exp_cnt = 8'd0;
    end else begin
      if (obs_del) begin
        if (q.size() > 0) exp_res = q.pop_front();
        else begin exp_res = 3'bxxx; underflow = 1; end
      end
      if (obs_acc) q.push_back(ref_cmp(xv, yv, s));
      if (cnt_clear) exp_cnt = 8'd0;
      else if (obs_del && exp_res == R_LT && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    n_cmp++; if (obs_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", obs_ov); end
    n_cmp++; if (obs_res !== 3'b000) begin n_fail++; $display("FAIL reset_lt_eq_gt: got %b want 000", obs_res); end
    n_cmp++; if (obs_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lt_count: got %0d want 0", obs_cnt); end
    reset = 1'b0;
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    n_cmp++; if (obs_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", obs_ir); end
  endtask

  task automatic send_directed(input logic [8:0] a, input logic [8:0] b, input logic s,
                               input logic [2:0] want, input string name);
    int lat;
    lat = 0;
    run_cycle(1, a, b, s, 1);
    n_cmp++; if (obs_acc !== 1'b1) begin n_fail++; $display("FAIL %s_accept: got %b want 1", name, obs_acc); end
    for (int c = 1; c <= 6; c++) begin
      run_cycle(0, 9'h0, 9'h0, 0, 1);
      if (obs_ov === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
    n_cmp++; if (obs_res !== want) begin n_fail++; $display("FAIL %s_result: got %b want %b", name, obs_res, want); end
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    n_cmp++; if (obs_cnt !== cnt_now) begin n_fail++; $display("FAIL %s_lt_count: got %0d want %0d", name, obs_cnt, cnt_now); end
  endtask

  task automatic test_directed();
    send_directed(9'h0FF, 9'h100, 0, R_LT, "unsigned_lt");
    n_cmp++; if (obs_cnt !== 8'd1) begin n_fail++; $display("FAIL first_lt_count: got %0d want 1", obs_cnt); end
    send_directed(9'h100, 9'h001, 1, R_LT, "signed_neg_lt");
    send_directed(9'h100, 9'h001, 0, R_GT, "unsigned_gt");
    send_directed(9'h155, 9'h155, 0, R_EQ, "eq_unsigned");
    send_directed(9'h155, 9'h155, 1, R_EQ, "eq_signed");
    send_directed(9'h1C0, 9'h040, 0, R_GT, "stage0_decide");
    send_directed(9'h0A3, 9'h0A5, 0, R_LT, "last_stage_decide");
    send_directed(9'h1FE, 9'h1FF, 1, R_LT, "signed_both_neg");
  endtask

  task automatic test_back_to_back();
    int first, last, ndel;
    first = -1; last = -1; ndel = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) begin
        run_cycle(1, pick_op(), pick_op(), 1'($urandom), 1);
        n_cmp++; if (obs_acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1 at %0d", obs_acc, c); end
      end else begin
        run_cycle(0, 9'h0, 9'h0, 0, 1);
      end
      if (obs_del) begin
        ndel++;
        if (first < 0) first = c;
        last = c;
        n_cmp++; if (obs_res !== exp_res) begin n_fail++; $display("FAIL b2b_result: got %b want %b", obs_res, exp_res); end
      end
    end
    n_cmp++; if (first != 3 || last != 8 || ndel != 6)
      begin n_fail++; $display("FAIL b2b_timing: got first=%0d last=%0d n=%0d want 3/8/6", first, last, ndel); end

    for (int c = 0; c < 3; c++) begin
      run_cycle(1, pick_op(), pick_op(), 1'($urandom), 1);
      n_cmp++; if (obs_acc !== 1'b1) begin n_fail++; $display("FAIL stall_fill_accept: got %b want 1", obs_acc); end
    end
    for (int c = 0; c < 4; c++) begin
      run_cycle(1, pick_op(), pick_op(), 0, 0);
      n_cmp++; if (obs_ir !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", obs_ir); end
      n_cmp++; if (obs_ov !== 1'b1 || obs_res !== head_exp)
        begin n_fail++; $display("FAIL stall_hold: got v=%b r=%b want v=1 r=%b", obs_ov, obs_res, head_exp); end
    end
    ndel = 0;
    for (int c = 0; c < 8; c++) begin
      run_cycle(0, 9'h0, 9'h0, 0, 1);
      if (obs_del) begin
        ndel++;
        n_cmp++; if (obs_res !== exp_res) begin n_fail++; $display("FAIL stall_drain_result: got %b want %b", obs_res, exp_res); end
      end
    end
    n_cmp++; if (ndel != 3 || q.size() != 0)
      begin n_fail++; $display("FAIL stall_no_loss: got %0d delivered, %0d left want 3/0", ndel, q.size()); end
  endtask

  task automatic test_reset_inflight();
    int stale;
    stale = 0;
    run_cycle(1, 9'h001, 9'h002, 0, 1);
    run_cycle(1, 9'h003, 9'h004, 0, 1);
    reset = 1'b1;
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    reset = 1'b0;
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    n_cmp++; if (obs_ov !== 1'b0) begin n_fail++; $display("FAIL inflight_out_valid: got %b want 0", obs_ov); end
    n_cmp++; if (obs_cnt !== 8'd0) begin n_fail++; $display("FAIL inflight_lt_count: got %0d want 0", obs_cnt); end
    for (int c = 0; c < 6; c++) begin
      run_cycle(0, 9'h0, 9'h0, 0, 1);
      if (obs_ov !== 1'b0 || obs_res !== 3'b000) stale++;
    end
    n_cmp++; if (stale != 0) begin n_fail++; $display("FAIL inflight_stale: got %0d stale cycles want 0", stale); end
  endtask

  task automatic test_saturation();
    int a, b;
    for (int i = 0; i < 305; i++) begin
      a = $urandom_range(0, 510);
      b = $urandom_range(a + 1, 511);
      run_cycle(1, 9'(a), 9'(b), 0, 1);
      if (obs_del) begin
        n_cmp++; if (obs_res !== exp_res) begin n_fail++; $display("FAIL sat_result: got %b want %b", obs_res, exp_res); end
      end
    end
    for (int c = 0; c < 5; c++) run_cycle(0, 9'h0, 9'h0, 0, 1);
    n_cmp++; if (obs_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_lt_count: got %0d want 255", obs_cnt); end
    n_cmp++; if (obs_cnt !== cnt_now) begin n_fail++; $display("FAIL sat_model: got %0d want %0d", obs_cnt, cnt_now); end
  endtask

  task automatic test_clear_priority();
    run_cycle(1, 9'h005, 9'h009, 0, 1);
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    cnt_clear = 1'b1;
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    cnt_clear = 1'b0;
    n_cmp++; if (obs_del !== 1'b1 || obs_res !== R_LT)
      begin n_fail++; $display("FAIL clear_same_cycle_lt: got del=%b r=%b want 1/100", obs_del, obs_res); end
    n_cmp++; if (obs_cnt !== 8'd255) begin n_fail++; $display("FAIL clear_before: got %0d want 255", obs_cnt); end
    run_cycle(0, 9'h0, 9'h0, 0, 1);
    n_cmp++; if (obs_cnt !== 8'd0) begin n_fail++; $display("FAIL clear_priority: got %0d want 0", obs_cnt); end
  endtask

  task automatic test_random();
    logic [8:0] a, b;
    logic       v, s, ordy, prev_stall;
    prev_stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      a = pick_op();
      b = ($urandom_range(0, 3) == 0) ? a : pick_op();
      v = ($urandom_range(0, 9) < 7);
      s = 1'($urandom);
      ordy = (c >= 394) || ($urandom_range(0, 9) < 7);
      cnt_clear = ($urandom_range(0, 39) == 0);
      run_cycle(v, a, b, s, ordy);
      n_cmp++; if (obs_ir !== (!obs_ov || ordy)) begin n_fail++; $display("FAIL rnd_in_ready: got %b at %0d", obs_ir, c); end
      n_cmp++; if (obs_cnt !== cnt_now) begin n_fail++; $display("FAIL rnd_lt_count: got %0d want %0d", obs_cnt, cnt_now); end
      if (obs_ov === 1'b1) begin
        n_cmp++; if (!has_head || obs_res !== head_exp)
          begin n_fail++; $display("FAIL rnd_result: got %b want %b (pending=%0d)", obs_res, head_exp, has_head); end
      end else begin
        n_cmp++; if (obs_res !== 3'b000) begin n_fail++; $display("FAIL rnd_idle_zero: got %b want 000", obs_res); end
      end
      if (prev_stall) begin
        n_cmp++; if (obs_ov !== 1'b1) begin n_fail++; $display("FAIL rnd_stall_valid: got %b want 1", obs_ov); end
      end
      prev_stall = obs_ov && !ordy;
    end
    cnt_clear = 1'b0;
    for (int c = 0; c < 6; c++) begin
      run_cycle(0, 9'h0, 9'h0, 0, 1);
      if (obs_del) begin
        n_cmp++; if (obs_res !== exp_res) begin n_fail++; $display("FAIL rnd_drain: got %b want %b", obs_res, exp_res); end
      end
    end
    n_cmp++; if (q.size() != 0 || underflow)
      begin n_fail++; $display("FAIL rnd_scoreboard: got %0d left, extra=%0d want 0/0", q.size(), underflow); end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; signed_mode = 1'b0;
    out_ready = 1'b1; cnt_clear = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_saturation();
    test_clear_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
